// File: rtl/mul_acc_if.sv
// Stream bundle between the shift-multiply stage, mul_acc and the frame consumer.
// Latency: none, wires only.
// Backpressure: in_valid/in_ready on the operand side, out_valid/out_ready on the result side.
//
// Signals:
//   in_valid, in_ready          operand handshake
//   a, mul2, mul4, mul8, be4    raw operand and the upstream products of it
//   sel                         term select, travels with the operand
//   out_valid, out_ready        frame result handshake
//   sum, be4_cnt, ovf           frame result
// Modports: master = producer/consumer side, slave = mul_acc.
interface mul_acc_if #(
  parameter int ACC_W = 12
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       a;
  logic [7:0]       mul2;
  logic [7:0]       mul4;
  logic [7:0]       mul8;
  logic             be4;
  logic [1:0]       sel;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] sum;
  logic [3:0]       be4_cnt;
  logic             ovf;

  modport master (
    output in_valid, a, mul2, mul4, mul8, be4, sel, out_ready,
    input  in_ready, out_valid, sum, be4_cnt, ovf
  );

  modport slave (
    input  in_valid, a, mul2, mul4, mul8, be4, sel, out_ready,
    output in_ready, out_valid, sum, be4_cnt, ovf
  );
endinterface

// File: rtl/mul_acc.sv
// Frame accumulator: sums a selected scaled term over N_SAMPLES operands, counts multiples of 4.
// Latency: 1 cycle from the final accept edge to out_valid; one operand per cycle while accumulating.
// Backpressure: in_ready low while a result waits; result held stable until out_ready.
//
// Ports:
//   clk        single clock, rising edge
//   rst_n      synchronous active-low reset
//   bus        mul_acc_if.slave: operand handshake + products in, frame result handshake out
// Parameters:
//   N_SAMPLES  operands per frame (1..15)
//   ACC_W      accumulator width (>= 8)
// Build option:
//   MUL_ACC_SAT_EN  when defined, the accumulator clamps at 2^ACC_W-1 on carry-out instead of
//                   wrapping; ovf is set on carry-out either way.
module mul_acc #(
  parameter int N_SAMPLES = 8,
  parameter int ACC_W     = 12
) (
  input logic      clk,
  input logic      rst_n,
  mul_acc_if.slave bus
);

  typedef enum logic {
    ACC  = 1'b0,
    DONE = 1'b1
  } state_t;

  // Counter value of the operand that closes the frame.
  localparam logic [3:0] LAST_IDX = 4'(N_SAMPLES - 1);

  state_t           state;
  logic [ACC_W-1:0] acc;
  logic [3:0]       cnt;
  logic [3:0]       be4_cnt;
  logic             ovf;
  logic             in_ready;
  logic             out_valid;

  logic [7:0]       term8;
  logic [ACC_W:0]   add;
  logic             carry;
  logic [ACC_W-1:0] acc_next;
  logic             accept;

  // Products come from upstream already shifted; they are used as-is.
  always_comb begin
    term8 = 8'd0;
    case (bus.sel)
      2'd0:    term8 = {4'b0000, bus.a};
      2'd1:    term8 = bus.mul2;
      2'd2:    term8 = bus.mul4;
      default: term8 = bus.mul8;
    endcase
  end

  // One extra bit on the adder exposes the carry out of ACC_W bits.
  assign add   = {1'b0, acc} + (ACC_W + 1)'(term8);
  assign carry = add[ACC_W];

`ifdef MUL_ACC_SAT_EN
  // Once clamped, any further non-zero term carries again, so the
  // accumulator stays pinned at full scale for the rest of the frame.
  assign acc_next = carry ? {ACC_W{1'b1}} : add[ACC_W-1:0];
`else
  assign acc_next = add[ACC_W-1:0];
`endif

  // in_ready is only ever high in ACC, but the state term keeps the
  // accept condition self-evident.
  assign accept = (state == ACC) && bus.in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ACC;
      acc       <= '0;
      cnt       <= 4'd0;
      be4_cnt   <= 4'd0;
      ovf       <= 1'b0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        ACC: begin
          // Raised on the first edge out of reset and kept up while accumulating.
          in_ready <= 1'b1;
          if (accept) begin
            acc     <= acc_next;
            be4_cnt <= be4_cnt + {3'b000, bus.be4};
            ovf     <= ovf | carry;
            if (cnt == LAST_IDX) begin
              // Final term lands in acc on this same edge, so the result is
              // complete when out_valid appears.
              cnt       <= cnt;
              state     <= DONE;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
            end else begin
              cnt <= cnt + 4'd1;
            end
          end
        end

        DONE: begin
          // Operand side is closed; in_valid is ignored here.
          in_ready <= 1'b0;
          if (out_ready_q()) begin
            state     <= ACC;
            acc       <= '0;
            cnt       <= 4'd0;
            be4_cnt   <= 4'd0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end

        default: begin
          state     <= ACC;
          in_ready  <= 1'b0;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

  // Output handshake: out_valid is registered, so this is the edge on
  // which the consumer takes the frame.
  function automatic logic out_ready_q();
    return out_valid && bus.out_ready;
  endfunction

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.sum       = acc;
  assign bus.be4_cnt   = be4_cnt;
  assign bus.ovf       = ovf;

endmodule

// File: tb/tb_mul_acc.sv
// Bench for mul_acc: three instances (default, 8-bit accumulator, single-sample frame).
// Latency: inputs driven on the falling edge, outputs sampled on the falling edge.
// Backpressure: out_ready held low for random/directed spans while the result is checked stable.
module tb_mul_acc;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  mul_acc_if #(.ACC_W(12)) if0 ();
  mul_acc_if #(.ACC_W(8))  if1 ();
  mul_acc_if #(.ACC_W(12)) if2 ();

  mul_acc #(.N_SAMPLES(8), .ACC_W(12)) u0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave));
  mul_acc #(.N_SAMPLES(8), .ACC_W(8))  u1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
  mul_acc #(.N_SAMPLES(1), .ACC_W(12)) u2 (.clk(clk), .rst_n(rst_n), .bus(if2.slave));

  int q_a[$];
  int q_sel[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: the term is the operand scaled by 2^sel; the running total
  // either wraps or clamps when it no longer fits in w bits.
  function automatic int term_of(input int a, input int sel);
    return a * (1 << sel);
  endfunction

  function automatic void acc_model(inout int s, inout bit o, input int t, input int w);
    s = s + t;
    if (s >= (1 << w)) begin
      o = 1'b1;
`ifdef MUL_ACC_SAT_EN
      s = (1 << w) - 1;
`else
      s = s - (1 << w);
`endif
    end
  endfunction

  task automatic put0(input int a, input int sel);
    if0.a    = 4'(a);
    if0.sel  = 2'(sel);
    if0.mul2 = 8'(a * 2);
    if0.mul4 = 8'(a * 4);
    if0.mul8 = 8'(a * 8);
    if0.be4  = (a % 4 == 0);
  endtask

  // Present one operand on if0 and return on the falling edge after it was taken.
  task automatic send0(input string nm, input int a, input int sel);
    int budget;
    put0(a, sel);
    if0.in_valid = 1'b1;
    budget = 0;
    while (!if0.in_ready && budget < 20) begin
      @(negedge clk);
      budget++;
    end
    chk({nm, "_in_ready"}, 32'(if0.in_ready), 32'd1);
    @(negedge clk);
    if0.in_valid = 1'b0;
  endtask

  // Sends the queued frame on if0, checks the result, holds it for `hold`
  // cycles (optionally with in_valid asserted), then completes the handshake.
  task automatic run_frame0(input string nm, input int gap, input int hold, input bit junk);
    int  exp_sum = 0;
    int  exp_cnt = 0;
    bit  exp_ovf = 1'b0;
    int  g;
    for (int i = 0; i < q_a.size(); i++) begin
      g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
      repeat (g) @(negedge clk);
      send0(nm, q_a[i], q_sel[i]);
      acc_model(exp_sum, exp_ovf, term_of(q_a[i], q_sel[i]), 12);
      if (q_a[i] % 4 == 0) exp_cnt++;
      if (i != q_a.size() - 1) chk({nm, "_early_valid"}, 32'(if0.out_valid), 32'd0);
    end
    chk({nm, "_out_valid"}, 32'(if0.out_valid), 32'd1);
    chk({nm, "_in_ready_done"}, 32'(if0.in_ready), 32'd0);
    chk({nm, "_sum"}, 32'(if0.sum), 32'(exp_sum));
    chk({nm, "_be4_cnt"}, 32'(if0.be4_cnt), 32'(exp_cnt));
    chk({nm, "_ovf"}, 32'(if0.ovf), 32'(exp_ovf));
    for (int h = 0; h < hold; h++) begin
      if (junk) begin
        put0(int'($urandom_range(0, 15)), int'($urandom_range(0, 3)));
        if0.in_valid = 1'b1;
      end
      @(negedge clk);
      chk({nm, "_hold_valid"}, 32'(if0.out_valid), 32'd1);
      chk({nm, "_hold_in_ready"}, 32'(if0.in_ready), 32'd0);
      chk({nm, "_hold_sum"}, 32'(if0.sum), 32'(exp_sum));
      chk({nm, "_hold_be4"}, 32'(if0.be4_cnt), 32'(exp_cnt));
    end
    if0.in_valid  = 1'b0;
    if0.out_ready = 1'b1;
    @(negedge clk);
    if0.out_ready = 1'b0;
    chk({nm, "_post_valid"}, 32'(if0.out_valid), 32'd0);
    chk({nm, "_post_in_ready"}, 32'(if0.in_ready), 32'd1);
    chk({nm, "_post_sum"}, 32'(if0.sum), 32'd0);
    chk({nm, "_post_be4"}, 32'(if0.be4_cnt), 32'd0);
    chk({nm, "_post_ovf"}, 32'(if0.ovf), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    int s;
    bit o;
    int mix_a[8]   = '{8, 2, 12, 5, 0, 1, 4, 15};
    int mix_sel[8] = '{0, 1, 2, 3, 0, 1, 2, 3};

    rst_n = 1'b0;
    if0.in_valid = 1'b0; if0.out_ready = 1'b0; put0(0, 0);
    if1.in_valid = 1'b0; if1.out_ready = 1'b0;
    if1.a = 4'd0; if1.sel = 2'd0; if1.mul2 = 8'd0; if1.mul4 = 8'd0; if1.mul8 = 8'd0; if1.be4 = 1'b1;
    if2.in_valid = 1'b0; if2.out_ready = 1'b0;
    if2.a = 4'd0; if2.sel = 2'd0; if2.mul2 = 8'd0; if2.mul4 = 8'd0; if2.mul8 = 8'd0; if2.be4 = 1'b1;

    repeat (3) @(negedge clk);
    chk("rst_in_ready", 32'(if0.in_ready), 32'd0);
    chk("rst_out_valid", 32'(if0.out_valid), 32'd0);
    chk("rst_sum", 32'(if0.sum), 32'd0);
    chk("rst_be4", 32'(if0.be4_cnt), 32'd0);
    chk("rst_ovf", 32'(if0.ovf), 32'd0);
    chk("rst_w8_in_ready", 32'(if1.in_ready), 32'd0);
    chk("rst_n1_out_valid", 32'(if2.out_valid), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_in_ready", 32'(if0.in_ready), 32'd1);
    chk("rel_out_valid", 32'(if0.out_valid), 32'd0);

    // a=3, sel=1 back to back: 8 * 6 = 48.
    q_a.delete(); q_sel.delete();
    for (int i = 0; i < 8; i++) begin q_a.push_back(3); q_sel.push_back(1); end
    run_frame0("f48", 0, 0, 1'b0);

    // a=4, sel=3 with five cycles of backpressure: 8 * 32 = 256, all multiples of 4.
    q_a.delete(); q_sel.delete();
    for (int i = 0; i < 8; i++) begin q_a.push_back(4); q_sel.push_back(3); end
    run_frame0("f256", 0, 5, 1'b0);

    // Mixed terms with in_valid every other cycle: 238, four multiples of 4.
    q_a.delete(); q_sel.delete();
    for (int i = 0; i < 8; i++) begin q_a.push_back(mix_a[i]); q_sel.push_back(mix_sel[i]); end
    run_frame0("fmix", 1, 1, 1'b1);

    // Random frames with random gaps, backpressure and in_valid during DONE.
    for (int f = 0; f < 6; f++) begin
      q_a.delete(); q_sel.delete();
      for (int i = 0; i < 8; i++) begin
        q_a.push_back(int'($urandom_range(0, 15)));
        q_sel.push_back(int'($urandom_range(0, 3)));
      end
      run_frame0("frnd", -1, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    // 8-bit accumulator, 8 x 120 = 960 overflows.
    if1.a = 4'd15; if1.sel = 2'd3; if1.mul2 = 8'd30; if1.mul4 = 8'd60; if1.mul8 = 8'd120; if1.be4 = 1'b0;
    if1.in_valid = 1'b1;
    n = 0;
    for (int c = 0; c < 40 && n < 8; c++) begin
      if (if1.in_ready) n++;
      @(negedge clk);
    end
    if1.in_valid = 1'b0;
    chk("w8_accepts", 32'(n), 32'd8);
    s = 0; o = 1'b0;
    for (int i = 0; i < 8; i++) acc_model(s, o, term_of(15, 3), 8);
    chk("w8_out_valid", 32'(if1.out_valid), 32'd1);
    chk("w8_sum", 32'(if1.sum), 32'(s));
    chk("w8_ovf", 32'(if1.ovf), 32'(o));
    chk("w8_be4", 32'(if1.be4_cnt), 32'd0);
    if1.out_ready = 1'b1;
    @(negedge clk);
    if1.out_ready = 1'b0;
    chk("w8_post_valid", 32'(if1.out_valid), 32'd0);
    chk("w8_post_ovf", 32'(if1.ovf), 32'd0);

    // Single-sample frames: every operand is a frame, in_ready alternates.
    if2.a = 4'd6; if2.sel = 2'd2; if2.mul2 = 8'd12; if2.mul4 = 8'd24; if2.mul8 = 8'd48; if2.be4 = 1'b0;
    if2.out_ready = 1'b1;
    if2.in_valid  = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("n1_in_ready", 32'(if2.in_ready), 32'(i % 2 == 0));
      chk("n1_out_valid", 32'(if2.out_valid), 32'(i % 2 == 1));
      if (i % 2 == 1) chk("n1_sum", 32'(if2.sum), 32'(term_of(6, 2)));
      @(negedge clk);
    end
    if2.in_valid = 1'b0;

    // Reset after five accepted operands discards the partial frame.
    for (int i = 0; i < 5; i++) send0("prst", int'($urandom_range(0, 15)), int'($urandom_range(0, 3)));
    chk("prst_valid", 32'(if0.out_valid), 32'd0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mrst_in_ready", 32'(if0.in_ready), 32'd0);
    chk("mrst_out_valid", 32'(if0.out_valid), 32'd0);
    chk("mrst_sum", 32'(if0.sum), 32'd0);
    chk("mrst_be4", 32'(if0.be4_cnt), 32'd0);
    chk("mrst_ovf", 32'(if0.ovf), 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("mrst_no_valid", 32'(if0.out_valid), 32'd0);
      chk("mrst_ready", 32'(if0.in_ready), 32'd1);
    end
    q_a.delete(); q_sel.delete();
    for (int i = 0; i < 8; i++) begin q_a.push_back(1); q_sel.push_back(0); end
    run_frame0("f8", 0, 1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mul_acc.md
# mul_acc

Sequential accumulator directly downstream of the shift-multiply stage. Accepts one operand per valid/ready handshake together with that stage's `mul2`/`mul4`/`mul8`/`be4` results. Accumulates a selected scaled term over a fixed frame of `N_SAMPLES` operands and counts multiples of 4. Presents the frame result on a valid/ready output port.

## Interface

Parameters:
- `N_SAMPLES`, 8: operands per frame; legal range 1..15.
- `ACC_W`, 12: accumulator width; legal range ≥ 8.

Ports:
- `clk`, input, 1: single clock; all state updates on rising edge.
- `rst_n`, input, 1: reset is synchronous and active-low.
- `in_valid`, input, 1: operand and products valid.
- `in_ready`, output, 1: block can accept an operand this cycle.
- `a`, input, 4: raw operand.
- `mul2`, input, 8: `a<<1` from the upstream stage.
- `mul4`, input, 8: `a<<2` from the upstream stage.
- `mul8`, input, 8: `a<<3` from the upstream stage.
- `be4`, input, 1: 1 when `a%4==0`.
- `sel`, input, 2: term select, sampled with the operand.
- `out_valid`, output, 1: frame result valid.
- `out_ready`, input, 1: consumer takes the result.
- `sum`, output, ACC_W: accumulated sum of the frame.
- `be4_cnt`, output, 4: number of operands in the frame with `be4=1`.
- `ovf`, output, 1: sticky per frame; set if any addition carried out of `ACC_W` bits.

## Operation

- States: ACC and DONE. Reset enters ACC.
- Term selection, zero-extended to `ACC_W`:
  - `sel=0` → `{4'b0,a}`
  - `sel=1` → `mul2`
  - `sel=2` → `mul4`
  - `sel=3` → `mul8`
- Inputs are trusted; no internal recompute of products.
- In ACC, an operand is accepted when `in_valid && in_ready`. On acceptance:
  - `acc += term`
  - `be4_cnt += be4`
  - `ovf |= carry`
  - sample counter increments.
- Accepting the `N_SAMPLES`-th operand transitions ACC→DONE. The final term is included in the result.
- In DONE:
  - `out_valid=1` and `in_ready=0`.
  - `sum`/`be4_cnt`/`ovf` are held stable until `out_valid && out_ready`.
- On the output handshake:
  - acc, `be4_cnt`, `ovf` and sample counter clear to 0.
  - State returns to ACC.
- `in_valid` in DONE is ignored; no operand is consumed.
- `in_valid` low in ACC: no state change. Gaps of any length are allowed within a frame.
- `N_SAMPLES=1`: every accepted operand produces a frame.

## Timing

- All outputs are registered.
- Reset values: `in_ready=0`, `out_valid=0`, `sum=0`, `be4_cnt=0`, `ovf=0`, state ACC, counter 0.
- `in_ready` rises in the first cycle after `rst_n` deasserts.
- `in_ready` drops in the cycle after the last operand is accepted. `out_valid` rises in that same cycle: latency is 1 cycle from the final accept edge to `out_valid`.
- On the output handshake edge:
  - `out_valid` falls and `in_ready` rises in the next cycle.
  - Back-to-back frames cost one idle input cycle.
- Throughput: one operand per cycle in ACC.
- Reset asserted mid-frame or during DONE:
  - Partial frame is discarded.
  - All outputs return to reset values on the next edge.
  - No `out_valid` pulse is produced for the discarded frame.

## Configuration

- `MUL_ACC_SAT_EN` defined:
  - On carry-out, acc clamps to `2^ACC_W-1` and stays there for the rest of the frame.
  - `ovf` is set.
- `MUL_ACC_SAT_EN` undefined:
  - acc wraps modulo `2^ACC_W`.
  - `ovf` is still set on any carry-out.

## Test plan

- Defaults, 8 operands with `a=3`, `sel=1` (`mul2=6`), `in_valid` held high → `out_valid` 1 cycle after 8th accept, `sum=48`, `be4_cnt=0`, `ovf=0`.
- 8 operands with `a=4`, `sel=3` (`mul8=32`), `out_ready` held low for 5 cycles → `sum=256`, `be4_cnt=8`, held stable for all 5 cycles; `in_ready=0` throughout; cleared after handshake.
- Mixed frame with `(a,sel)` = (8,0), (2,1), (12,2), (5,3), (0,0), (1,1), (4,2), (15,3), with `in_valid` toggled every other cycle → `sum=8+4+48+40+0+2+16+120=238`, `be4_cnt=4`.
- `ACC_W=8`, 8 operands with `a=15`, `sel=3` (120 each, 960 total) → `ovf=1`; `sum=192` with macro undefined, `sum=255` with `MUL_ACC_SAT_EN`.
- Reset pulsed after 5 accepted operands, then a full frame of `a=1`, `sel=0` → no `out_valid` for the partial frame; next frame `sum=8`, `be4_cnt=0`.
- `N_SAMPLES=1`, `out_ready` tied high, `in_valid` high, `a=6`, `sel=2` → `sum=24` every frame, `in_ready` pattern 1,0,1,0.
